framebuffer_write_arbiter: RTL and testbench

Shares the single VGA framebuffer write port (19-bit pixel address, 3-bit colour, write enable) among several drawing engines: character typer, trajectory plotter, target sprite drawer and screen clearer. Each engine holds a level request for a whole transaction, for example one character or one sprite. The arbiter grants one engine at a time in round-robin order and forwards that engine's write beats through a registered mux. A hold watchdog revokes a grant that is never released.

---
 rtl/framebuffer_write_arbiter_if.sv | 29 ++
 rtl/framebuffer_write_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_framebuffer_write_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/framebuffer_write_arbiter_if.sv
// Bundles the requester write beats, grant status and framebuffer write port
// shared by the drawing engines and framebuffer_write_arbiter.
interface framebuffer_write_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 3
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_waddr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_wen;
    logic [NUM_REQ-1:0]        grant;
    logic [2:0]                grant_id;
    logic                      busy;
    logic [ADDR_W-1:0]         mem_waddr;
    logic [DATA_W-1:0]         mem_wdata;
    logic                      mem_wenable;
    logic [NUM_REQ-1:0]        timeout;

    modport master (
        output req, req_waddr, req_wdata, req_wen,
        input  grant, grant_id, busy, mem_waddr, mem_wdata, mem_wenable, timeout
    );

    modport slave (
        input  req, req_waddr, req_wdata, req_wen,
        output grant, grant_id, busy, mem_waddr, mem_wdata, mem_wenable, timeout
    );
endinterface

// File: rtl/framebuffer_write_arbiter.sv
// Round-robin, non-preemptive arbiter for the single VGA framebuffer write port,
// with a hold watchdog. Define FB_PRIORITY_EN to give requester 0 fixed top priority.
module framebuffer_write_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 3,
    parameter int MAX_HOLD = 4096
) (
    input  logic                             clock,
    input  logic                             resetn,
    framebuffer_write_arbiter_if.slave       bus
);
    localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = {{(HOLD_W-1){1'b0}}, 1'b1};
    localparam logic [NUM_REQ-1:0] REQ_ONE  = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t              state_r,       state_nxt_s;
    logic [2:0]          last_r,        last_nxt_s;
    logic [HOLD_W-1:0]   hold_r,        hold_nxt_s;
    logic [NUM_REQ-1:0]  lockout_r,     lockout_nxt_s;
    logic [NUM_REQ-1:0]  timeout_r,     timeout_nxt_s;
    logic [NUM_REQ-1:0]  grant_r,       grant_nxt_s;
    logic [2:0]          grant_id_r,    grant_id_nxt_s;
    logic                busy_r,        busy_nxt_s;
    logic [ADDR_W-1:0]   mem_waddr_r,   mem_waddr_nxt_s;
    logic [DATA_W-1:0]   mem_wdata_r,   mem_wdata_nxt_s;
    logic                mem_wenable_r, mem_wenable_nxt_s;

    logic [NUM_REQ-1:0]  elig_s;
    logic [NUM_REQ-1:0]  rr_elig_s;
    logic                hi_found_s, lo_found_s, pick_found_s, pick_prio_s;
    logic [2:0]          hi_idx_s, lo_idx_s, pick_idx_s;
    logic                req_g_s, wen_g_s;
    logic [ADDR_W-1:0]   sel_waddr_s;
    logic [DATA_W-1:0]   sel_wdata_s;

    // Arbitration pick: first eligible index above the pointer, else the first one from 0.
    always_comb begin
        elig_s = bus.req & ~lockout_r;
`ifdef FB_PRIORITY_EN
        rr_elig_s = elig_s & ~REQ_ONE;
`else
        rr_elig_s = elig_s;
`endif
        hi_found_s = 1'b0;
        hi_idx_s   = 3'd0;
        lo_found_s = 1'b0;
        lo_idx_s   = 3'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hi_idx_s   = (rr_elig_s[i] && (i > int'(last_r)) && !hi_found_s) ? 3'(i) : hi_idx_s;
            hi_found_s = hi_found_s | (rr_elig_s[i] && (i > int'(last_r)));
            lo_idx_s   = (rr_elig_s[i] && !lo_found_s) ? 3'(i) : lo_idx_s;
            lo_found_s = lo_found_s | rr_elig_s[i];
        end
        pick_found_s = hi_found_s | lo_found_s;
        pick_idx_s   = hi_found_s ? hi_idx_s : lo_idx_s;
        pick_prio_s  = 1'b0;
`ifdef FB_PRIORITY_EN
        // The screen clearer wins outright and leaves the pointer alone.
        pick_prio_s  = elig_s[0];
        pick_found_s = pick_found_s | elig_s[0];
        pick_idx_s   = elig_s[0] ? 3'd0 : pick_idx_s;
`endif
    end

    // Grantee's request, write enable and beat, selected by the one-hot grant.
    always_comb begin
        req_g_s     = |(bus.req & grant_r);
        wen_g_s     = |(bus.req_wen & grant_r);
        sel_waddr_s = {ADDR_W{1'b0}};
        sel_wdata_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_waddr_s = sel_waddr_s | (bus.req_waddr[i*ADDR_W +: ADDR_W] & {ADDR_W{grant_r[i]}});
            sel_wdata_s = sel_wdata_s | (bus.req_wdata[i*DATA_W +: DATA_W] & {DATA_W{grant_r[i]}});
        end
    end

    // Next-state and registered-output logic of the grant FSM.
    always_comb begin
        state_nxt_s       = state_r;
        last_nxt_s        = last_r;
        hold_nxt_s        = hold_r;
        lockout_nxt_s     = lockout_r & bus.req;
        timeout_nxt_s     = timeout_r;
        grant_nxt_s       = grant_r;
        grant_id_nxt_s    = grant_id_r;
        busy_nxt_s        = busy_r;
        mem_waddr_nxt_s   = mem_waddr_r;
        mem_wdata_nxt_s   = mem_wdata_r;
        mem_wenable_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_nxt_s    = ST_GRANT;
                    grant_nxt_s    = REQ_ONE << pick_idx_s;
                    grant_id_nxt_s = pick_idx_s;
                    busy_nxt_s     = 1'b1;
                    hold_nxt_s     = {HOLD_W{1'b0}};
                    last_nxt_s     = pick_prio_s ? last_r : pick_idx_s;
                end else begin
                    state_nxt_s    = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!req_g_s) begin
                    // Release takes precedence over a coincident watchdog expiry.
                    state_nxt_s    = ST_IDLE;
                    grant_nxt_s    = {NUM_REQ{1'b0}};
                    grant_id_nxt_s = 3'd0;
                    busy_nxt_s     = 1'b0;
                end else if (hold_r == HOLD_LAST) begin
                    state_nxt_s    = ST_IDLE;
                    grant_nxt_s    = {NUM_REQ{1'b0}};
                    grant_id_nxt_s = 3'd0;
                    busy_nxt_s     = 1'b0;
                    timeout_nxt_s  = timeout_r | grant_r;
                    lockout_nxt_s  = lockout_nxt_s | grant_r;
                end else begin
                    hold_nxt_s = hold_r + HOLD_ONE;
                    if (wen_g_s) begin
                        mem_waddr_nxt_s   = sel_waddr_s;
                        mem_wdata_nxt_s   = sel_wdata_s;
                        mem_wenable_nxt_s = 1'b1;
                    end else begin
                        mem_wenable_nxt_s = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                grant_nxt_s    = {NUM_REQ{1'b0}};
                grant_id_nxt_s = 3'd0;
                busy_nxt_s     = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r       <= ST_IDLE;
            last_r        <= 3'(NUM_REQ - 1);
            hold_r        <= {HOLD_W{1'b0}};
            lockout_r     <= {NUM_REQ{1'b0}};
            timeout_r     <= {NUM_REQ{1'b0}};
            grant_r       <= {NUM_REQ{1'b0}};
            grant_id_r    <= 3'd0;
            busy_r        <= 1'b0;
            mem_waddr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r   <= {DATA_W{1'b0}};
            mem_wenable_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            last_r        <= last_nxt_s;
            hold_r        <= hold_nxt_s;
            lockout_r     <= lockout_nxt_s;
            timeout_r     <= timeout_nxt_s;
            grant_r       <= grant_nxt_s;
            grant_id_r    <= grant_id_nxt_s;
            busy_r        <= busy_nxt_s;
            mem_waddr_r   <= mem_waddr_nxt_s;
            mem_wdata_r   <= mem_wdata_nxt_s;
            mem_wenable_r <= mem_wenable_nxt_s;
        end
    end

    assign bus.grant       = grant_r;
    assign bus.grant_id    = grant_id_r;
    assign bus.busy        = busy_r;
    assign bus.mem_waddr   = mem_waddr_r;
    assign bus.mem_wdata   = mem_wdata_r;
    assign bus.mem_wenable = mem_wenable_r;
    assign bus.timeout     = timeout_r;
endmodule

// File: tb/tb_framebuffer_write_arbiter.sv
// Directed bench for framebuffer_write_arbiter: expected write beats are queued
// when driven and compared when they appear on the framebuffer port.
module tb_framebuffer_write_arbiter;
    localparam int NR = 4;
    localparam int AW = 19;
    localparam int DW = 3;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } beat_t;

    logic  clock;
    logic  resetn;
    int    n_checks;
    int    n_fail;
    beat_t sb_q[$];

    framebuffer_write_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    framebuffer_write_arbiter #(
        .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(8)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_beat(input int r, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input bit expect_it);
        beat_t b;
        bus.req_waddr[r*AW +: AW] = a;
        bus.req_wdata[r*DW +: DW] = d;
        bus.req_wen[r]            = 1'b1;
        if (expect_it) begin
            b.addr = a;
            b.data = d;
            sb_q.push_back(b);
        end
    endtask

    // One clock edge, then compare the framebuffer port with the scoreboard.
    task automatic step();
        beat_t e;
        bit    pending;
        @(posedge clock);
        #1;
        pending = (sb_q.size() > 0);
        chk("mem_wenable", 32'(bus.mem_wenable), 32'(pending));
        if (pending) begin
            e = sb_q.pop_front();
            chk("mem_waddr", 32'(bus.mem_waddr), 32'(e.addr));
            chk("mem_wdata", 32'(bus.mem_wdata), 32'(e.data));
        end
        bus.req_wen = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [NR-1:0] rr_all;
        logic [NR-1:0] rr_exp [5];
        int            rr_id  [5];
        int            rr_n;
        logic [NR-1:0] cur;

        n_checks = 0;
        n_fail   = 0;
`ifdef FB_PRIORITY_EN
        rr_all = 4'b1110;
        rr_n   = 4;
        rr_exp[0] = 4'b0010; rr_exp[1] = 4'b0100; rr_exp[2] = 4'b1000; rr_exp[3] = 4'b0010; rr_exp[4] = 4'b0000;
        rr_id[0]  = 1;       rr_id[1]  = 2;       rr_id[2]  = 3;       rr_id[3]  = 1;       rr_id[4]  = 0;
`else
        rr_all = 4'b1111;
        rr_n   = 5;
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100; rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
        rr_id[0]  = 0;       rr_id[1]  = 1;       rr_id[2]  = 2;       rr_id[3]  = 3;       rr_id[4]  = 0;
`endif

        // Reset state
        resetn        = 1'b0;
        bus.req       = '0;
        bus.req_waddr = '0;
        bus.req_wdata = '0;
        bus.req_wen   = '0;
        #3;
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_wen", 32'(bus.mem_wenable), 32'd0);
        chk("rst_timeout", 32'(bus.timeout), 32'd0);
        chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
        @(posedge clock);
        @(posedge clock);
        #3;
        resetn = 1'b1;
        step();
        chk("idle_grant", 32'(bus.grant), 32'd0);

        // Round-robin fairness with one beat per grant
        bus.req = rr_all;
        for (int k = 0; k < rr_n; k++) begin
            step();
            chk("rr_grant", 32'(bus.grant), 32'(rr_exp[k]));
            chk("rr_grant_id", 32'(bus.grant_id), 32'(rr_id[k]));
            drive_beat(rr_id[k], AW'(200 + k), DW'(k), 1'b1);
            step();
            step();
            bus.req = rr_all & ~rr_exp[k];
            step();
            chk("rr_release_grant", 32'(bus.grant), 32'd0);
            chk("rr_release_busy", 32'(bus.busy), 32'd0);
            bus.req = (k == rr_n - 1) ? 4'b0000 : rr_all;
        end
        step();
        chk("rr_end_idle", 32'(bus.busy), 32'd0);

        // Single requester with three back-to-back beats
        bus.req = 4'b0010;
        step();
        chk("single_grant", 32'(bus.grant), 32'b0010);
        chk("single_id", 32'(bus.grant_id), 32'd1);
        chk("single_busy", 32'(bus.busy), 32'd1);
        for (int a = 100; a <= 102; a++) begin
            drive_beat(1, AW'(a), 3'b101, 1'b1);
            step();
        end
        bus.req = 4'b0000;
        drive_beat(1, AW'(103), 3'b011, 1'b0);
        step();
        chk("single_release_busy", 32'(bus.busy), 32'd0);
        chk("single_addr_hold", 32'(bus.mem_waddr), 32'd102);
        step();

        // Beats from a non-granted requester are dropped
        bus.req = 4'b0001;
        step();
        chk("ign_grant", 32'(bus.grant), 32'b0001);
        drive_beat(0, AW'(10), 3'b001, 1'b1);
        drive_beat(2, AW'(500), 3'b111, 1'b0);
        step();
        drive_beat(2, AW'(500), 3'b111, 1'b0);
        step();
        chk("ign_addr_hold", 32'(bus.mem_waddr), 32'd10);
        drive_beat(0, AW'(11), 3'b010, 1'b1);
        drive_beat(2, AW'(500), 3'b111, 1'b0);
        step();
        bus.req = 4'b0000;
        step();
        step();

        // Watchdog revocation after MAX_HOLD grant cycles, then lockout
        bus.req = 4'b1000;
        step();
        chk("wd_grant", 32'(bus.grant), 32'b1000);
        for (int k = 0; k < 7; k++) begin
            step();
            chk("wd_hold", 32'(bus.grant), 32'b1000);
        end
        step();
        chk("wd_revoked", 32'(bus.grant), 32'd0);
        chk("wd_busy", 32'(bus.busy), 32'd0);
        chk("wd_timeout", 32'(bus.timeout), 32'b1000);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("wd_locked", 32'(bus.grant), 32'd0);
        end
        bus.req = 4'b0000;
        step();
        bus.req = 4'b1000;
        step();
        chk("wd_regrant", 32'(bus.grant), 32'b1000);
        bus.req = 4'b0000;
        step();
        chk("wd_timeout_sticky", 32'(bus.timeout), 32'b1000);

        // Asynchronous reset in the middle of a beat
        bus.req = 4'b0001;
        step();
        chk("ar_grant", 32'(bus.grant), 32'b0001);
        drive_beat(0, AW'(42), 3'b011, 1'b1);
        step();
        drive_beat(0, AW'(43), 3'b010, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        chk("ar_wen", 32'(bus.mem_wenable), 32'd0);
        chk("ar_grant_zero", 32'(bus.grant), 32'd0);
        chk("ar_busy", 32'(bus.busy), 32'd0);
        chk("ar_timeout", 32'(bus.timeout), 32'd0);
        chk("ar_waddr", 32'(bus.mem_waddr), 32'd0);
        bus.req     = 4'b0000;
        bus.req_wen = '0;
        #3;
        resetn = 1'b1;
        step();
        chk("ar_idle", 32'(bus.grant), 32'd0);
        bus.req = 4'b0001;
        step();
        chk("ar_regrant", 32'(bus.grant), 32'b0001);
        bus.req = 4'b0000;
        step();
        step();

        // Late request from requester 0 while requester 1 holds the port
        bus.req = 4'b0110;
        step();
        chk("pr_grant1", 32'(bus.grant), 32'b0010);
        bus.req = 4'b0111;
        step();
        chk("pr_no_preempt", 32'(bus.grant), 32'b0010);
        bus.req = 4'b0101;
        step();
        chk("pr_release", 32'(bus.grant), 32'd0);
        step();
`ifdef FB_PRIORITY_EN
        cur = 4'b0001;
`else
        cur = 4'b0100;
`endif
        chk("pr_second", 32'(bus.grant), 32'(cur));
        bus.req = 4'b0101 & ~cur;
        step();
        chk("pr_release2", 32'(bus.busy), 32'd0);
        step();
        chk("pr_third", 32'(bus.grant), 32'(4'b0101 & ~cur));
        bus.req = 4'b0000;
        step();
        chk("pr_end_busy", 32'(bus.busy), 32'd0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
